// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, error codes and width helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
  function automatic int clogb2(input int unsigned value);
    int unsigned v;
    int          r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - payload byte stream between parser and consumer
interface uart_frame_parser_if;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       m_last_o;

  modport master (output m_data_o, output m_valid_o, output m_last_o, input m_ready_i);
  modport slave  (input m_data_o, input m_valid_o, input m_last_o, output m_ready_i);
endinterface

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload buffer with registered read port
module uart_frame_buf #(
  parameter int MAX_LEN = 64,
  parameter int PTR_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [MAX_LEN];

  // Storage: contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read: the parser presents next-cycle address for zero-bubble streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SOF/LEN/payload/XOR framed packet parser
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         UART_CLK_MHZ = 50,
  parameter int         MAX_LEN      = 64,
  parameter int         TIMEOUT_US   = 2000,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_int_i,
  uart_frame_parser_if.master        m,
  output logic                       frame_ok_o,
  output logic                       frame_err_o,
  output logic [1:0]                 err_code_o,
  output logic [7:0]                 drop_cnt_o,
  output logic                       busy_o
);

  localparam int TIMEOUT_NCLK = UART_CLK_MHZ * TIMEOUT_US;
  localparam int TMR_W = (clogb2(TIMEOUT_NCLK) < 1) ? 1 : clogb2(TIMEOUT_NCLK);
  localparam int PTR_W = (clogb2(MAX_LEN) < 1) ? 1 : clogb2(MAX_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_NCLK - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  state_e           state_q, state_n;
  logic [7:0]       len_q, len_n;
  logic [7:0]       chk_q, chk_n;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_n;
  logic [TMR_W-1:0] timer_q, timer_n;
  logic [7:0]       drop_n;
  logic [1:0]       err_code_n;
  logic             ok_n, err_n, wr_en, timing;

  uart_frame_buf #(.MAX_LEN(MAX_LEN), .PTR_W(PTR_W)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (rx_data_i),
    .rd_addr (rd_ptr_n),
    .rd_data (m.m_data_o)
  );

  // Next-state, datapath and pulse decisions for one byte event or drain step.
  always_comb begin
    state_n    = state_q;
    len_n      = len_q;
    chk_n      = chk_q;
    wr_ptr_n   = wr_ptr_q;
    rd_ptr_n   = rd_ptr_q;
    timer_n    = '0;
    drop_n     = drop_cnt_o;
    err_code_n = err_code_o;
    ok_n       = 1'b0;
    err_n      = 1'b0;
    wr_en      = 1'b0;
    timing     = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

    if (timing) timer_n = rx_int_i ? '0 : timer_q + TMR_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (rx_int_i && rx_data_i == SOF_BYTE) state_n = ST_LEN;
      end
      ST_LEN: begin
        if (rx_int_i) begin
          if (rx_data_i == 8'd0 || rx_data_i > MAX_LEN_B) begin
            state_n    = ST_IDLE;
            err_n      = 1'b1;
            err_code_n = ERR_LEN;
          end else begin
            len_n    = rx_data_i;
            chk_n    = rx_data_i;
            wr_ptr_n = '0;
            state_n  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_int_i) begin
          wr_en    = 1'b1;
          chk_n    = chk_q ^ rx_data_i;
          wr_ptr_n = wr_ptr_q + PTR_W'(1);
          if (8'(wr_ptr_q) == len_q - 8'd1) state_n = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_int_i) begin
          if (rx_data_i == chk_q) begin
            state_n  = ST_DRAIN;
            rd_ptr_n = '0;
            ok_n     = 1'b1;
          end else begin
            state_n    = ST_IDLE;
            err_n      = 1'b1;
            err_code_n = ERR_CHK;
          end
        end
      end
      ST_DRAIN: begin
        // Bytes arriving while the payload is still owned by the consumer are lost.
        if (rx_int_i && drop_cnt_o != 8'hFF) drop_n = drop_cnt_o + 8'd1;
        if (m.m_valid_o && m.m_ready_i) begin
          if (m.m_last_o) state_n = ST_IDLE;
          else            rd_ptr_n = rd_ptr_q + PTR_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A byte landing on the terminal count keeps the frame alive.
    if (timing && !rx_int_i && timer_q == TMR_LAST) begin
      state_n    = ST_IDLE;
      err_n      = 1'b1;
      err_code_n = ERR_TIMEOUT;
      timer_n    = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      chk_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      timer_q     <= '0;
      drop_cnt_o  <= '0;
      err_code_o  <= '0;
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
      m.m_valid_o <= 1'b0;
      m.m_last_o  <= 1'b0;
    end else begin
      state_q     <= state_n;
      len_q       <= len_n;
      chk_q       <= chk_n;
      wr_ptr_q    <= wr_ptr_n;
      rd_ptr_q    <= rd_ptr_n;
      timer_q     <= timer_n;
      drop_cnt_o  <= drop_n;
      err_code_o  <= err_code_n;
      frame_ok_o  <= ok_n;
      frame_err_o <= err_n;
      busy_o      <= (state_n != ST_IDLE);
      m.m_valid_o <= (state_n == ST_DRAIN);
      m.m_last_o  <= (state_n == ST_DRAIN) && (8'(rd_ptr_n) == len_n - 8'd1);
    end
  end

endmodule
